mis_stim_gen: RTL
=================

# mis_stim_gen

Clocked stimulus-and-capture sequencer for the multiple-input-switching (MIS) NOR test structures. It drives the two DUT inputs `myin_A` and `myin_B` with a programmable launch skew and polarity, then samples the DUT output `myout` through a synchronizer. It reports the clock-cycle latency from the first input launch to the first output change. It sits in the test harness between the measurement controller and the NOR chain under test.

## Interface
- `SKEW_W`, 8: width of the signed skew operand.
- `CNT_W`, 16: width of the hold and latency counters.
- `TIMEOUT`, 1023: MEASURE cycles before the block gives up; must be < 2^CNT_W.
- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `dir` in 1: launch polarity. 1 = inputs rise 0→1; 0 = inputs fall 1→0.
- `skew` in SKEW_W: signed. >0 = B launches `skew` cycles after A; <0 = A launches |skew| cycles after B; 0 = both in the same cycle.
- `hold_cycles` in CNT_W: PRESET duration. 0 is treated as 1.
- `myout` in 1: asynchronous DUT output.
- `myin_A` out 1: DUT input A.
- `myin_B` out 1: DUT input B.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a measurement ends.
- `timeout` out 1: valid with `done`; 1 = no output change was seen.
- `latency` out CNT_W: cycle count of the last measurement; held until the next `done`.

## Operation
- Reset values: `myin_A`=0, `myin_B`=0, `busy`=0, `done`=0, `timeout`=0, `latency`=0, synchronizer flops=0, FSM=IDLE.
- `dir`, `skew` and `hold_cycles` are captured into registers on the accepted `start`. Changes to these inputs while busy are ignored.
- `myout` passes through a 2-flop synchronizer before any use.

FSM states:
- IDLE: outputs hold their last levels. `start`=1 → PRESET.
- PRESET: drive both inputs to `~dir` for max(hold_cycles,1) cycles. On the last cycle, capture the synchronized output as `ref_level`.
- LAUNCH1: toggle the leading input(s) to `dir`. For skew=0, toggle both and go to MEASURE. Otherwise load `|skew|-1` into the skew counter and go to WAIT_SKEW. The latency counter resets to 1 in this cycle.
- WAIT_SKEW: decrement the skew counter; at 0 → LAUNCH2. The latency counter keeps counting.
- LAUNCH2: toggle the lagging input to `dir` → MEASURE.
- MEASURE: each cycle, compare the synchronized output with `ref_level`.
  - If they differ: `latency` = counter value, `timeout`=0 → DONE.
  - If the counter reaches TIMEOUT: `latency`=TIMEOUT, `timeout`=1 → DONE.

Output detection rules:
- An output change detected during WAIT_SKEW or LAUNCH2 counts as detected. Record it and finish the remaining launch, then go to DONE without entering the MEASURE wait.

Other states and rules:
- DONE: `done`=1 for exactly one cycle → IDLE. Inputs stay at `dir`.
- `skew` = most-negative value: its magnitude is taken as an unsigned SKEW_W value, e.g. −128 → 128 cycles. No overflow.
- `rst` in any state forces the reset values on the next edge. `done` is not emitted and `latency` is cleared.
- `start` outside IDLE is ignored. It is not queued.

## Timing
- Launch edge of the leading input: appears 1 + max(hold,1) cycles after the `start` cycle.
- Lagging input: toggles exactly |skew| cycles after the leading input.
- Latency definition: LAUNCH1 is cycle 1. `latency` = number of cycles up to and including the cycle in which the synchronized change is seen.
  - This includes the 2-cycle synchronizer delay; the block does not subtract it.
  - Minimum reported value is 3 for a combinational DUT.
- `done` is asserted in the cycle after detection. `latency` and `timeout` are valid from that same edge.

## Structure
- A shared package `mis_pkg` holds:
  - the FSM state enum {IDLE, PRESET, LAUNCH1, WAIT_SKEW, LAUNCH2, MEASURE, DONE};
  - the synchronizer depth constant (2);
  - default widths.
- Sub-module `mis_sync2`: parameterless 2-flop synchronizer with synchronous reset to 0. It is instantiated once for `myout`.
- Everything else lives in one module: FSM, skew counter, hold counter, latency counter.

## Test plan
- Loopback (`myout` = `myin_A`), dir=1, skew=0, hold=4 → both inputs rise 5 cycles after `start`; `latency`=3, `timeout`=0, `done` pulse one cycle wide.
- `myout` = NOR(A,B) modelled with 0 delay, dir=1, skew=+5 → A rises, B rises 5 cycles later; output falls in response to A; `latency`=3. Verify B still rises before `done`.
- skew=−3, dir=0, `myout` delayed 10 cycles from B → B falls first, A falls 3 cycles later; `latency`=13.
- `myout` tied constant, TIMEOUT=1023 → `done` with `timeout`=1 and `latency`=1023; inputs remain at `dir`.
- Assert `rst` during WAIT_SKEW → next cycle: all outputs 0, `busy`=0, no `done`. A subsequent `start` runs normally.
- `start` pulsed while busy, `hold_cycles`=0 → second `start` ignored; PRESET lasts exactly 1 cycle.

Source files
------------

// File: rtl/mis_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mis_pkg                                                    |
// | Shared types and constants for the MIS NOR stimulus/capture          |
// | sequencer: FSM state encoding, synchronizer depth, default widths.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mis_pkg;

  // Sequencer states; 3 bits covers all seven.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESET    = 3'd1,
    ST_LAUNCH1   = 3'd2,
    ST_WAIT_SKEW = 3'd3,
    ST_LAUNCH2   = 3'd4,
    ST_MEASURE   = 3'd5,
    ST_DONE      = 3'd6
  } mis_state_e;

  // Number of flops between the asynchronous DUT output and any use of it.
  localparam int SYNC_DEPTH = 2;

  // Default operand widths and measurement limit.
  localparam int DEF_SKEW_W  = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1023;

endpackage : mis_pkg
`default_nettype wire

// File: rtl/mis_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mis_sync2                                                  |
// | Two-flop synchronizer for a single asynchronous bit, synchronous     |
// | active-high reset to 0.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mis_sync2
  import mis_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  // Shift the raw input into the chain; oldest sample sits in the MSB.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], async_in};
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_DEPTH-1];

endmodule : mis_sync2
`default_nettype wire

// File: rtl/mis_stim_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mis_stim_gen                                               |
// | Drives the two inputs of an MIS NOR structure with programmable      |
// | polarity and launch skew, watches the synchronized output and        |
// | reports the cycle latency from first launch to first output change.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mis_stim_gen
  import mis_pkg::*;
#(
  parameter int SKEW_W  = DEF_SKEW_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dir,
  input  logic signed [SKEW_W-1:0] skew,
  input  logic        [CNT_W-1:0]  hold_cycles,
  input  logic                     myout,
  output logic                     myin_A,
  output logic                     myin_B,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic        [CNT_W-1:0]  latency
);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  mis_state_e                state_q,     state_d;
  logic                      dir_q,       dir_d;
  logic signed [SKEW_W-1:0]  skew_q,      skew_d;
  logic        [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
  logic        [SKEW_W-1:0]  skew_cnt_q,  skew_cnt_d;
  logic        [CNT_W-1:0]   lat_cnt_q,   lat_cnt_d;
  logic                      ref_q,       ref_d;
  logic                      det_q,       det_d;
  logic        [CNT_W-1:0]   det_lat_q,   det_lat_d;
  logic                      myin_a_q,    myin_a_d;
  logic                      myin_b_q,    myin_b_d;
  logic                      busy_q,      busy_d;
  logic                      done_q,      done_d;
  logic                      timeout_q,   timeout_d;
  logic        [CNT_W-1:0]   latency_q,   latency_d;

  // Combinational helpers
  logic                      myout_sync;
  logic                      out_changed;
  logic                      skew_zero;
  logic                      b_leads;
  logic        [SKEW_W-1:0]  skew_mag;
  logic        [CNT_W-1:0]   hold_load;

  // ---------------------------------------------------------------------
  // Output synchronizer: myout is asynchronous to clk
  // ---------------------------------------------------------------------
  mis_sync2 u_sync_myout (
    .clk      (clk),
    .rst      (rst),
    .async_in (myout),
    .sync_out (myout_sync)
  );

  // Decode the captured skew and the requested hold length.
  always_comb begin
    skew_zero = (skew_q == '0);
    b_leads   = skew_q[SKEW_W-1];
    // Two's-complement negate read as unsigned: the most-negative value
    // maps to 2^(SKEW_W-1) cycles without overflow.
    skew_mag  = b_leads ? $unsigned(-skew_q) : $unsigned(skew_q);
    hold_load = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
    out_changed = (myout_sync != ref_q);
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    skew_d     = skew_q;
    hold_cnt_d = hold_cnt_q;
    skew_cnt_d = skew_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    ref_d      = ref_q;
    det_d      = det_q;
    det_lat_d  = det_lat_q;
    myin_a_d   = myin_a_q;
    myin_b_d   = myin_b_q;
    timeout_d  = timeout_q;
    latency_d  = latency_q;

    case (state_q)
      ST_IDLE: begin
        // Operands are frozen here so changes while busy have no effect.
        if (start) begin
          dir_d      = dir;
          skew_d     = skew;
          hold_cnt_d = hold_load;
          state_d    = ST_PRESET;
        end
      end

      ST_PRESET: begin
        if (hold_cnt_q <= CNT_W'(1)) begin
          // Reference level is taken in the final preset cycle.
          ref_d     = myout_sync;
          lat_cnt_d = CNT_W'(1);
          det_d     = 1'b0;
          state_d   = ST_LAUNCH1;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end

      ST_LAUNCH1: begin
        lat_cnt_d  = lat_cnt_q + CNT_W'(1);
        // Counter holds the number of WAIT_SKEW cycles still to spend.
        skew_cnt_d = skew_mag - SKEW_W'(1);
        if (skew_zero) begin
          state_d = ST_MEASURE;
        end else if (skew_mag == SKEW_W'(1)) begin
          state_d = ST_LAUNCH2;
        end else begin
          state_d = ST_WAIT_SKEW;
        end
      end

      ST_WAIT_SKEW: begin
        lat_cnt_d  = lat_cnt_q + CNT_W'(1);
        skew_cnt_d = skew_cnt_q - SKEW_W'(1);
        // An early response is latched; the lagging launch still happens.
        if (out_changed && !det_q) begin
          det_d     = 1'b1;
          det_lat_d = lat_cnt_q;
        end
        if (skew_cnt_d == '0) begin
          state_d = ST_LAUNCH2;
        end
      end

      ST_LAUNCH2: begin
        lat_cnt_d = lat_cnt_q + CNT_W'(1);
        if (det_q) begin
          latency_d = det_lat_q;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (out_changed) begin
          latency_d = lat_cnt_q;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        lat_cnt_d = lat_cnt_q + CNT_W'(1);
        // A seen change wins over the limit in the same cycle.
        if (out_changed) begin
          latency_d = lat_cnt_q;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (lat_cnt_q >= CNT_W'(TIMEOUT)) begin
          latency_d = CNT_W'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Input drive levels are registered so they change on the edge that
    // enters the corresponding state.
    if (state_d == ST_PRESET && state_q != ST_PRESET) begin
      myin_a_d = ~dir_d;
      myin_b_d = ~dir_d;
    end else if (state_d == ST_LAUNCH1) begin
      if (skew_zero || !b_leads) begin
        myin_a_d = dir_q;
      end
      if (skew_zero || b_leads) begin
        myin_b_d = dir_q;
      end
    end else if (state_d == ST_LAUNCH2) begin
      myin_a_d = dir_q;
      myin_b_d = dir_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // All sequencer state; reset returns every output to 0 and drops any
  // measurement in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      skew_q     <= '0;
      hold_cnt_q <= '0;
      skew_cnt_q <= '0;
      lat_cnt_q  <= '0;
      ref_q      <= 1'b0;
      det_q      <= 1'b0;
      det_lat_q  <= '0;
      myin_a_q   <= 1'b0;
      myin_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      latency_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      skew_q     <= skew_d;
      hold_cnt_q <= hold_cnt_d;
      skew_cnt_q <= skew_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      ref_q      <= ref_d;
      det_q      <= det_d;
      det_lat_q  <= det_lat_d;
      myin_a_q   <= myin_a_d;
      myin_b_q   <= myin_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      latency_q  <= latency_d;
    end
  end

  assign myin_A  = myin_a_q;
  assign myin_B  = myin_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign latency = latency_q;

endmodule : mis_stim_gen
`default_nettype wire
